// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial a - b - bin with start/busy/done handshake
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_nb;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    full_subtractor_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_nb)
    );

    // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    assign res_next = {cell_d, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        a_sh   <= io.a;
                        b_sh   <= io.b;
                        borrow <= io.bin;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= cell_nb;
                    // Counter stops at WIDTH-1 so it never wraps for power-of-two widths.
                    if (cnt == LAST) begin
                        diff_q <= res_next;
                        bout_q <= cell_nb;
                        done_q <= 1'b1;
                        state  <= DONE_S;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE_S: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.diff = diff_q;
    assign io.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8 and 16
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .io(if8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .io(if16));

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model(input int w, input longint a, input longint b, input bit bi,
                                  output longint d, output bit bo);
        longint r;
        r  = a - b - longint'(bi);
        d  = r & ((longint'(1) << w) - 1);
        bo = (r < 0);
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bo, output int lat);
        logic [7:0] prev;
        bit held;
        @(negedge clk);
        prev = if8.diff;
        held = 1;
        if8.a = a; if8.b = b; if8.bin = bi; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
        lat = 1;
        check("busy_after_accept8", if8.busy, 1);
        while (!if8.done && lat < 40) begin
            if (if8.diff !== prev) held = 0;
            @(negedge clk);
            lat++;
        end
        check("diff_held_in_shift8", held, 1);
        d  = if8.diff;
        bo = if8.bout;
        @(negedge clk);
        check("idle_after_done8", {if8.busy, if8.done}, 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output logic [15:0] d, output logic bo, output int lat);
        @(negedge clk);
        if16.a = a; if16.b = b; if16.bin = bi; if16.start = 1'b1;
        @(negedge clk);
        if16.start = 1'b0;
        if16.a = 16'($urandom); if16.b = 16'($urandom); if16.bin = 1'($urandom);
        lat = 1;
        while (!if16.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d  = if16.diff;
        bo = if16.bout;
        @(negedge clk);
        check("idle_after_done16", {if16.busy, if16.done}, 0);
    endtask

    initial begin
        logic [7:0]  d8;
        logic [15:0] d16;
        logic        bo;
        int          lat, n, dc, bl, badpos;
        longint      md;
        bit          mbo;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[5] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1};

        rst_n = 1'b0;
        if8.start = 0;  if8.a = 0;  if8.b = 0;  if8.bin = 0;
        if16.start = 0; if16.a = 0; if16.b = 0; if16.bin = 0;
        repeat (3) @(negedge clk);
        check("reset8", {if8.busy, if8.done, if8.diff, if8.bout}, 0);
        check("reset16", {if16.busy, if16.done, if16.diff, if16.bout}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, d8, bo, lat);
            check("vec_diff", d8, vecs[i].d);
            check("vec_bout", bo, vecs[i].bo);
            check("vec_latency", lat, 9);
        end

        // start pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        if8.a = 8'h80; if8.b = 8'h01; if8.bin = 0; if8.start = 1;
        @(negedge clk); if8.start = 0; n = 1;
        @(negedge clk); n++;
        @(negedge clk); n++;
        if8.a = 8'h11; if8.b = 8'h11; if8.start = 1;
        @(negedge clk); n++; if8.start = 0;
        while (!if8.done && n < 40) begin @(negedge clk); n++; end
        check("ign_latency", n, 9);
        if8.a = 8'h11; if8.b = 8'h11; if8.start = 1;
        @(negedge clk); if8.start = 0;
        check("ign_diff", if8.diff, 8'h7F);
        check("ign_bout", if8.bout, 0);
        dc = 0; bl = 0;
        repeat (20) begin
            if (if8.done) dc++;
            if (if8.busy) bl++;
            @(negedge clk);
        end
        check("ign_extra_done", dc, 0);
        check("ign_extra_busy", bl, 0);

        // start held high: back-to-back issue every WIDTH+2 cycles
        if8.a = 8'h10; if8.b = 8'h01; if8.bin = 0; if8.start = 1;
        @(negedge clk);
        dc = 0; bl = 0; badpos = 0;
        for (int k = 1; k <= 29; k++) begin
            if (if8.done) begin
                dc++;
                check("held_diff", if8.diff, 8'h0F);
            end
            if (if8.done != ((k % 10) == 9)) badpos++;
            if (!if8.busy) bl++;
            @(negedge clk);
        end
        if8.start = 0;
        check("held_done_count", dc, 3);
        check("held_done_pos", badpos, 0);
        check("held_busy_low", bl, 2);
        repeat (12) @(negedge clk);

        // asynchronous reset mid-operation
        op8(8'h5A, 8'h3C, 0, d8, bo, lat);
        check("pre_abort_diff", d8, 8'h1E);
        @(negedge clk);
        if8.a = 8'h01; if8.b = 8'h02; if8.bin = 0; if8.start = 1;
        @(negedge clk); if8.start = 0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {if8.busy, if8.done, if8.diff, if8.bout}, 0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        dc = 0; bl = 0;
        repeat (20) begin
            if (if8.done) dc++;
            if (if8.busy) bl++;
            @(negedge clk);
        end
        check("abort_no_done", dc, 0);
        check("abort_no_busy", bl, 0);
        op8(8'h01, 8'h02, 0, d8, bo, lat);
        check("post_abort_diff", d8, 8'hFF);
        check("post_abort_bout", bo, 1);

        // reset coincident with start: not accepted
        @(negedge clk);
        rst_n = 1'b0; if8.a = 8'h33; if8.b = 8'h11; if8.start = 1;
        @(negedge clk); rst_n = 1'b1; if8.start = 0;
        @(negedge clk);
        check("reset_beats_start", if8.busy, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            op8(ra, rb, rbi, d8, bo, lat);
            model(8, longint'(ra), longint'(rb), rbi, md, mbo);
            check("rand8_diff", d8, md);
            check("rand8_bout", bo, mbo);
            check("rand8_latency", lat, 9);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rbi;
            ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
            if (i == 0) begin ra = 16'h0000; rb = 16'hFFFF; rbi = 1; end
            op16(ra, rb, rbi, d16, bo, lat);
            model(16, longint'(ra), longint'(rb), rbi, md, mbo);
            check("rand16_diff", d16, md);
            check("rand16_bout", bo, mbo);
            check("rand16_latency", lat, 17);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
